dht11_responder: RTL and testbench
==================================

DHT11_RESPONDER -- requirements
Module: dht11_responder

Interface
REQ-001 Parameter TICKS_PER_US, default 50: clk cycles per microsecond (50 MHz).
REQ-002 Parameter START_MIN_US, default 18000: minimum host start-low duration that is accepted.
REQ-003 Port clk  input  1: single clock; all logic is on its rising edge.
REQ-004 Port rst  input  1: reset; asynchronous, active-high.
REQ-005 Port io_data  inout  1: single-wire data line; the block drives only 0 or Z, and an external pull-up supplies the high level.
REQ-006 Port i_enable  input  1: when 1, the block responds to host start pulses.
REQ-007 Ports i_hum_int, i_hum_dec, i_temp_int, i_temp_dec  input  8 each: measurement bytes to transmit.
REQ-008 Port o_busy  output  1: 1 from detection of a valid start pulse until the frame ends.
REQ-009 Port o_done  output  1: single-cycle pulse when a frame completes.
REQ-010 Port o_drive_low  output  1: internal drive state (1 = io_data pulled low), for debug.

Function
REQ-011 io_data input SHALL pass through a 2-FF synchronizer; all decisions use the synchronized value.
REQ-012 A free-running microsecond tick SHALL be generated; all durations are counted in ticks (±1 us tolerance).
REQ-013 States SHALL be: IDLE, START_LOW, WAIT_RELEASE, RESP_DELAY, RESP_LOW, RESP_HIGH, BIT_LOW, BIT_HIGH, END_LOW.
REQ-014 IDLE -> START_LOW when i_enable=1 and the line is low; otherwise remain in IDLE.
REQ-015 In START_LOW, the low time SHALL be counted; if the line rises before START_MIN_US, return to IDLE with no response.
REQ-016 Once START_MIN_US is reached, o_busy=1, the four input bytes and the checksum SHALL be latched, and the state goes to WAIT_RELEASE.
REQ-017 WAIT_RELEASE -> RESP_DELAY when the line goes high; RESP_DELAY lasts 30 us with the line released.
REQ-018 RESP_LOW SHALL drive low for 80 us; RESP_HIGH SHALL release for 80 us.
REQ-019 40 bits SHALL be sent MSB-first in the order hum_int, hum_dec, temp_int, temp_dec, checksum.
REQ-020 Each bit SHALL consist of BIT_LOW (drive low 50 us), then BIT_HIGH (release 26 us for a 0, 70 us for a 1).
REQ-021 After bit 39, END_LOW SHALL drive low 50 us, then release; o_done pulses for 1 cycle, o_busy -> 0, and the state returns to IDLE.
REQ-022 Checksum SHALL equal the sum of the four bytes modulo 256 (carry discarded).
REQ-023 Deasserting i_enable mid-frame SHALL NOT abort the frame; it only blocks the next start.
REQ-024 Input byte changes during a frame SHALL NOT affect the bits in flight.
REQ-025 The line SHALL never be driven high; io_data = Z whenever o_drive_low=0.
REQ-026 A start-low that exceeds START_MIN_US by any amount SHALL still be accepted; the response begins only after release.

Reset
REQ-027 rst=1 SHALL immediately release io_data (Z) and clear o_drive_low=0, o_busy=0, o_done=0, all counters=0, and state=IDLE, including mid-frame.
REQ-028 After reset is released, the block SHALL wait for a fresh start pulse; a low already in progress is counted from the first cycle out of reset.

Structure
REQ-029 Shared package dht11_pkg SHALL hold the state enum and timing constants (30/80/80/50/26/70/50 us and 40 bits).
REQ-030 The microsecond tick SHALL be a sub-module, us_tick_gen (parameter TICKS_PER_US; outputs a 1-cycle tick).
REQ-031 The remainder is one FSM plus a 40-bit shift register and a duration counter.

Verification
REQ-032 Bench uses TICKS_PER_US=2 and START_MIN_US=180.
REQ-033 Bytes 55,0,24,3; host low 200 us then release -> 30/80/80 us preamble, then bytes 0x37,0x00,0x18,0x03,0x52; o_done pulses once.
REQ-034 Bytes 0xFF,0xFF,0x01,0x02 -> checksum byte 0x01; bit 0 of the checksum is a 70 us high.
REQ-035 Host low 100 us -> line never driven low by the block; o_busy stays 0.
REQ-036 rst asserted during bit 12 -> io_data=Z in the same cycle, and o_busy=0; the next valid start yields a complete, correct frame.
REQ-037 i_enable=0 during the start pulse -> no response; i_enable dropped mid-frame -> frame completes; bytes changed mid-frame -> the originally latched values are sent.

Source files
------------

// File: rtl/dht11_pkg.sv
// Shared types and protocol timing for the DHT11 sensor-side responder.
// All durations are in microseconds and are counted against the us tick.
package dht11_pkg;

  typedef enum logic [3:0] {
    IDLE,
    START_LOW,
    WAIT_RELEASE,
    RESP_DELAY,
    RESP_LOW,
    RESP_HIGH,
    BIT_LOW,
    BIT_HIGH,
    END_LOW
  } state_t;

  localparam int T_RESP_DELAY_US = 30;
  localparam int T_RESP_LOW_US   = 80;
  localparam int T_RESP_HIGH_US  = 80;
  localparam int T_BIT_LOW_US    = 50;
  localparam int T_BIT0_HIGH_US  = 26;
  localparam int T_BIT1_HIGH_US  = 70;
  localparam int T_END_LOW_US    = 50;
  localparam int N_BITS          = 40;
  localparam int BIT_CNT_W       = 6;

  // Carry out of bit 7 is dropped by the 8-bit return type.
  function automatic logic [7:0] checksum(input logic [7:0] a, input logic [7:0] b,
                                          input logic [7:0] c, input logic [7:0] d);
    return a + b + c + d;
  endfunction

endpackage

// File: rtl/us_tick_gen.sv
// Free-running microsecond strobe: one-cycle pulse every TICKS_PER_US clocks.
module us_tick_gen #(
  parameter int TICKS_PER_US = 50
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int W = (TICKS_PER_US > 1) ? $clog2(TICKS_PER_US) : 1;

  logic [W-1:0] cnt;

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (cnt == W'(TICKS_PER_US - 1)) begin
      cnt  <= '0;
      tick <= 1'b1;
    end else begin
      cnt  <= cnt + W'(1);
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/dht11_responder.sv
// DHT11 sensor emulator: detects a host start pulse on the open-drain line and
// answers with the standard preamble, 40 data bits and a closing low pulse.
module dht11_responder
  import dht11_pkg::*;
#(
  parameter int TICKS_PER_US = 50,
  parameter int START_MIN_US = 18000
) (
  input  logic       clk,
  input  logic       rst,
  inout  wire        io_data,
  input  logic       i_enable,
  input  logic [7:0] i_hum_int,
  input  logic [7:0] i_hum_dec,
  input  logic [7:0] i_temp_int,
  input  logic [7:0] i_temp_dec,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_drive_low
);

  localparam int CNT_W = $clog2((START_MIN_US > 255) ? START_MIN_US + 1 : 256);

  state_t                 state, next_state;
  logic                   tick;
  logic                   line_meta, line_s;
  logic [CNT_W-1:0]       us_cnt;
  logic [BIT_CNT_W-1:0]   bit_cnt;
  logic [N_BITS-1:0]      shreg;
  logic                   latch, shift, done_set, last_bit;
  int                     bit_high_us;

  function automatic logic at_us(input logic [CNT_W-1:0] cnt, input int us);
    return cnt == CNT_W'(us - 1);
  endfunction

  us_tick_gen #(.TICKS_PER_US(TICKS_PER_US)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  // Synchronizer resets to the idle (pulled-up) level so reset never looks like a start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      line_meta <= 1'b1;
      line_s    <= 1'b1;
    end else begin
      line_meta <= io_data;
      line_s    <= line_meta;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  assign last_bit    = (bit_cnt == BIT_CNT_W'(N_BITS - 1));
  assign bit_high_us = shreg[N_BITS-1] ? T_BIT1_HIGH_US : T_BIT0_HIGH_US;

  // NOTE: every output of this block gets a default first, so no path through
  // the case statement can leave a value held and infer a latch.
  always_comb begin
    next_state = state;
    latch      = 1'b0;
    shift      = 1'b0;
    done_set   = 1'b0;
    unique case (state)
      IDLE:
        if (i_enable && !line_s) next_state = START_LOW;
      START_LOW:
        if (line_s) begin
          next_state = IDLE;
        end else if (tick && at_us(us_cnt, START_MIN_US)) begin
          next_state = WAIT_RELEASE;
          latch      = 1'b1;
        end
      WAIT_RELEASE:
        if (line_s) next_state = RESP_DELAY;
      RESP_DELAY:
        if (tick && at_us(us_cnt, T_RESP_DELAY_US)) next_state = RESP_LOW;
      RESP_LOW:
        if (tick && at_us(us_cnt, T_RESP_LOW_US)) next_state = RESP_HIGH;
      RESP_HIGH:
        if (tick && at_us(us_cnt, T_RESP_HIGH_US)) next_state = BIT_LOW;
      BIT_LOW:
        if (tick && at_us(us_cnt, T_BIT_LOW_US)) next_state = BIT_HIGH;
      BIT_HIGH:
        if (tick && at_us(us_cnt, bit_high_us)) begin
          shift      = 1'b1;
          next_state = last_bit ? END_LOW : BIT_LOW;
        end
      END_LOW:
        if (tick && at_us(us_cnt, T_END_LOW_US)) begin
          next_state = IDLE;
          done_set   = 1'b1;
        end
      default:
        next_state = IDLE;
    endcase
  end

  // Duration counter restarts on every state change; the shift register holds
  // the frame latched at start acceptance so later input changes cannot leak in.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      us_cnt  <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      o_done  <= 1'b0;
    end else begin
      o_done <= done_set;
      if (next_state != state) us_cnt <= '0;
      else if (tick)           us_cnt <= us_cnt + CNT_W'(1);
      if (latch) begin
        shreg   <= {i_hum_int, i_hum_dec, i_temp_int, i_temp_dec,
                    checksum(i_hum_int, i_hum_dec, i_temp_int, i_temp_dec)};
        bit_cnt <= '0;
      end else if (shift) begin
        shreg   <= {shreg[N_BITS-2:0], 1'b0};
        bit_cnt <= bit_cnt + BIT_CNT_W'(1);
      end
    end
  end

  assign o_busy      = state inside {WAIT_RELEASE, RESP_DELAY, RESP_LOW, RESP_HIGH,
                                     BIT_LOW, BIT_HIGH, END_LOW};
  assign o_drive_low = state inside {RESP_LOW, BIT_LOW, END_LOW};
  assign io_data     = o_drive_low ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_dht11_responder.sv
// Bench for dht11_responder: emulates the host on a pulled-up line and checks
// every low/high segment of the response against a queue of expected durations.
module tb_dht11_responder;

  localparam int TPU      = 2;
  localparam int SMIN     = 180;
  localparam int TOL      = 4;    // cycles of slack for tick phase and sync latency
  localparam int SEG_MAX  = 600;

  logic       clk = 1'b0;
  logic       rst;
  logic       i_enable;
  logic [7:0] hum_int, hum_dec, temp_int, temp_dec;
  logic       o_busy, o_done, o_drive_low;
  logic       host_low;
  wire        io_data;

  int n_checks  = 0;
  int n_fail    = 0;
  int done_cnt  = 0;
  int drive_err = 0;
  int exp_q[$];

  pullup (io_data);
  assign io_data = host_low ? 1'b0 : 1'bz;

  dht11_responder #(.TICKS_PER_US(TPU), .START_MIN_US(SMIN)) dut (
    .clk         (clk),
    .rst         (rst),
    .io_data     (io_data),
    .i_enable    (i_enable),
    .i_hum_int   (hum_int),
    .i_hum_dec   (hum_dec),
    .i_temp_int  (temp_int),
    .i_temp_dec  (temp_dec),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_drive_low (o_drive_low)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (o_done === 1'b1) done_cnt++;

  // The block may only pull low, and only while it reports doing so.
  always @(negedge clk) begin
    #2;
    if (o_drive_low === 1'b0 && host_low === 1'b0 && io_data === 1'b0) drive_err++;
    if (o_drive_low === 1'b1 && io_data !== 1'b0) drive_err++;
  end

  function automatic bit line_level();
    return (io_data === 1'b0) ? 1'b0 : 1'b1;
  endfunction

  task automatic set_bytes(input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] c, input logic [7:0] d);
    hum_int = a; hum_dec = b; temp_int = c; temp_dec = d;
  endtask

  task automatic push_frame(input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] c, input logic [7:0] d);
    logic [7:0]  cs;
    logic [39:0] bits;
    cs   = 8'((int'(a) + int'(b) + int'(c) + int'(d)) % 256);
    bits = {a, b, c, d, cs};
    exp_q.push_back(30);
    exp_q.push_back(80);
    exp_q.push_back(80);
    for (int i = 39; i >= 0; i--) begin
      exp_q.push_back(50);
      exp_q.push_back(bits[i] ? 70 : 26);
    end
    exp_q.push_back(50);
  endtask

  // Counts cycles from the current negedge until the line leaves lvl.
  task automatic measure(input bit lvl, output int cyc, output bit to);
    cyc = 0;
    to  = 1'b0;
    do begin
      @(negedge clk);
      cyc++;
      if (cyc > SEG_MAX) begin
        to = 1'b1;
        return;
      end
    end while (line_level() == lvl);
  endtask

  task automatic host_start(input int low_us);
    @(negedge clk);
    host_low = 1'b1;
    repeat (TPU * low_us) @(negedge clk);
    host_low = 1'b0;
  endtask

  task automatic capture_frame(input string name);
    bit lvl = 1'b1;
    int cyc, exp_us, seg;
    bit to;
    seg = 0;
    while (exp_q.size() > 0) begin
      exp_us = exp_q.pop_front();
      measure(lvl, cyc, to);
      n_checks++;
      if (to || cyc < TPU * exp_us - TOL || cyc > TPU * exp_us + TOL) begin
        n_fail++;
        $display("FAIL %s seg%0d level=%0d: got %0d cycles (timeout=%0d), want %0d +/- %0d",
                 name, seg, lvl, cyc, to, TPU * exp_us, TOL);
        if (to) begin
          exp_q.delete();
          return;
        end
      end
      lvl = ~lvl;
      seg++;
    end
  endtask

  task automatic check_frame_end(input string name, input int done_before);
    repeat (6) @(negedge clk);
    n_checks++;
    if (done_cnt - done_before !== 1) begin
      n_fail++;
      $display("FAIL %s done_pulses: got %0d want 1", name, done_cnt - done_before);
    end
    n_checks++;
    if (o_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s busy_after: got %b want 0", name, o_busy);
    end
  endtask

  task automatic run_frame(input string name, input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] c, input logic [7:0] d);
    int done_before;
    set_bytes(a, b, c, d);
    push_frame(a, b, c, d);
    repeat (20) @(negedge clk);
    done_before = done_cnt;
    host_start(200);
    n_checks++;
    if (o_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL %s busy_on_release: got %b want 1", name, o_busy);
    end
    capture_frame(name);
    check_frame_end(name, done_before);
  endtask

  // Host holds the line low for low_us; the block must stay silent and idle.
  task automatic expect_silence(input string name, input int low_us);
    int busy_seen = 0;
    int low_seen  = 0;
    @(negedge clk);
    host_low = 1'b1;
    repeat (TPU * low_us) begin
      @(negedge clk);
      if (o_busy !== 1'b0) busy_seen++;
    end
    host_low = 1'b0;
    repeat (TPU * 300) begin
      @(negedge clk);
      if (o_busy !== 1'b0) busy_seen++;
      if (io_data === 1'b0) low_seen++;
    end
    n_checks++;
    if (busy_seen !== 0) begin
      n_fail++;
      $display("FAIL %s busy_cycles: got %0d want 0", name, busy_seen);
    end
    n_checks++;
    if (low_seen !== 0) begin
      n_fail++;
      $display("FAIL %s line_low_cycles: got %0d want 0", name, low_seen);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (o_busy !== 1'b0 || o_done !== 1'b0 || o_drive_low !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got busy=%b done=%b drive=%b want 000",
               o_busy, o_done, o_drive_low);
    end
    n_checks++;
    if (io_data === 1'b0) begin
      n_fail++;
      $display("FAIL reset_line: got %b want released", io_data);
    end
    rst = 1'b0;
    repeat (10) @(negedge clk);
    n_checks++;
    if (o_busy !== 1'b0 || o_drive_low !== 1'b0 || io_data === 1'b0) begin
      n_fail++;
      $display("FAIL post_reset_idle: got busy=%b drive=%b line=%b want 0/0/released",
               o_busy, o_drive_low, io_data);
    end
  endtask

  task automatic test_basic_frame();
    run_frame("basic", 8'd55, 8'd0, 8'd24, 8'd3);
  endtask

  task automatic test_checksum_wrap();
    run_frame("cs_wrap", 8'hFF, 8'hFF, 8'h01, 8'h02);
  endtask

  task automatic test_short_start();
    expect_silence("short_start", 100);
  endtask

  task automatic test_enable();
    int done_before;
    i_enable = 1'b0;
    expect_silence("enable_off", 200);
    i_enable = 1'b1;
    set_bytes(8'hA5, 8'h3C, 8'h19, 8'h80);
    push_frame(8'hA5, 8'h3C, 8'h19, 8'h80);
    repeat (20) @(negedge clk);
    done_before = done_cnt;
    host_start(200);
    i_enable = 1'b0;
    set_bytes(8'h00, 8'hFF, 8'h5A, 8'h11);
    capture_frame("enable_drop");
    check_frame_end("enable_drop", done_before);
    i_enable = 1'b1;
  endtask

  task automatic test_reset_mid_frame();
    int cyc;
    bit to;
    bit lvl = 1'b1;
    bit lost = 1'b0;
    set_bytes(8'h12, 8'h34, 8'h56, 8'h78);
    repeat (20) @(negedge clk);
    host_start(200);
    // Skip the preamble (3 segments) and bits 0..11 (24 segments).
    for (int s = 0; s < 27 && !lost; s++) begin
      measure(lvl, cyc, to);
      if (to) lost = 1'b1;
      lvl = ~lvl;
    end
    n_checks++;
    if (lost) begin
      n_fail++;
      $display("FAIL rst_mid reach_bit12: got timeout want bit 12 reached");
    end
    repeat (10) @(negedge clk);
    n_checks++;
    if (o_drive_low !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_mid in_bit_low: got drive=%b want 1", o_drive_low);
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if (io_data === 1'b0 || o_drive_low !== 1'b0 || o_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid immediate: got line=%b drive=%b busy=%b want released/0/0",
               io_data, o_drive_low, o_busy);
    end
    @(negedge clk);
    rst = 1'b0;
    run_frame("after_rst", 8'h12, 8'h34, 8'h56, 8'h78);
  endtask

  task automatic test_line_integrity();
    n_checks++;
    if (drive_err !== 0) begin
      n_fail++;
      $display("FAIL line_integrity: got %0d bad samples want 0", drive_err);
    end
  endtask

  initial begin
    rst      = 1'b1;
    host_low = 1'b0;
    i_enable = 1'b1;
    set_bytes(8'h00, 8'h00, 8'h00, 8'h00);
    test_reset();
    test_basic_frame();
    test_checksum_wrap();
    test_short_start();
    test_enable();
    test_reset_mid_frame();
    test_line_integrity();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
